// File: rtl/cart_rom_loader.sv
`default_nettype none
//==============================================================================
// Module   : cart_rom_loader
// Purpose  : Power-up loader for the cartridge ROM image. Starts the SPI flash
//            loader, turns its toggle req/ack byte stream into single-cycle
//            BRAM write strobes, checks the byte count, enforces a millisecond
//            timeout, and keeps the C64 in reset (and the SPI mux on the
//            loader) until a complete image has been written.
//
// Ports    : clk          system clock (sysclk domain)
//            reset        asynchronous, active-high reset
//            ena_1khz     one-cycle 1 kHz tick
//            slot_valid   flash slot number from the USB micro is valid
//            retry        one-cycle restart request after a failed load
//            flash_start  one-cycle start pulse to the flash loader
//            flash_busy   flash loader busy
//            flash_req    toggle: new byte available
//            flash_ack    toggle acknowledge
//            flash_a      byte address from the flash loader
//            flash_q      byte data from the flash loader
//            bram_we      one-cycle BRAM write strobe
//            bram_a       BRAM write address
//            bram_d       BRAM write data
//            done         image loaded and verified (MMC64 owns SPI)
//            error        load failed
//            hold_reset   keep the C64 in reset
//            byte_count   bytes written in the current attempt
//            checksum     modulo-256 sum of bytes written
//
// Revision : 1.0 - initial release
//==============================================================================
module cart_rom_loader #(
    parameter int A_BITS         = 14,
    parameter int EXPECTED_BYTES = 8192,
    parameter int TIMEOUT_MS     = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ena_1khz,
    input  logic              slot_valid,
    input  logic              retry,
    output logic              flash_start,
    input  logic              flash_busy,
    input  logic              flash_req,
    output logic              flash_ack,
    input  logic [A_BITS-1:0] flash_a,
    input  logic [7:0]        flash_q,
    output logic              bram_we,
    output logic [A_BITS-1:0] bram_a,
    output logic [7:0]        bram_d,
    output logic              done,
    output logic              error,
    output logic              hold_reset,
    output logic [A_BITS:0]   byte_count,
    output logic [7:0]        checksum
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam int              c_ms_w     = (TIMEOUT_MS < 1) ? 1 : $clog2(TIMEOUT_MS + 1);
    localparam logic [A_BITS:0] c_expected = (A_BITS + 1)'(EXPECTED_BYTES);
    localparam logic [c_ms_w-1:0] c_timeout = c_ms_w'(TIMEOUT_MS);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_start     = 3'd1;
    localparam logic [2:0] c_st_wait_busy = 3'd2;
    localparam logic [2:0] c_st_load      = 3'd3;
    localparam logic [2:0] c_st_done      = 3'd4;
    localparam logic [2:0] c_st_error     = 3'd5;

    //--------------------------------------------------------------------------
    // Registers and combinational helpers
    //--------------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic              r_flash_ack;
    logic              r_bram_we;
    logic [A_BITS-1:0] r_bram_a;
    logic [7:0]        r_bram_d;
    logic [A_BITS:0]   r_byte_count;
    logic [7:0]        r_checksum;
    logic [c_ms_w-1:0] r_ms_count;

    logic w_toggle;
    logic w_loading;
    logic w_full;
    logic w_accept;
    logic w_overflow;
    logic w_complete;
    logic w_timeout;

    // A toggle is pending whenever the loader's req differs from our ack.
    assign w_toggle   = flash_req ^ r_flash_ack;
    assign w_loading  = (r_state == c_st_wait_busy) || (r_state == c_st_load);
    assign w_full     = (r_byte_count == c_expected);
    assign w_accept   = w_loading && w_toggle && !w_full;
    assign w_overflow = w_loading && w_toggle && w_full;
    assign w_timeout  = (r_ms_count == c_timeout);

    // The completion check waits for the write pipeline to drain (no pending
    // toggle, no strobe in flight) so a last byte that arrives together with
    // the falling busy is always counted before the verdict.
    assign w_complete = (r_state == c_st_load) && !flash_busy && !w_toggle && !r_bram_we;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (slot_valid) begin
                    w_state_next = c_st_start;
                end
            end
            c_st_start: begin
                w_state_next = c_st_wait_busy;
            end
            c_st_wait_busy: begin
                if (w_overflow || w_timeout) begin
                    w_state_next = c_st_error;
                end else if (flash_busy) begin
                    w_state_next = c_st_load;
                end
            end
            c_st_load: begin
                // Completion verdict outranks a coincident timeout.
                if (w_complete) begin
                    w_state_next = w_full ? c_st_done : c_st_error;
                end else if (w_overflow || w_timeout) begin
                    w_state_next = c_st_error;
                end
            end
            c_st_done: begin
                w_state_next = c_st_done;
            end
            c_st_error: begin
                if (retry) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: state-decoded outputs
    //--------------------------------------------------------------------------
    always_comb begin
        flash_start = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (r_state)
            c_st_start: flash_start = 1'b1;
            c_st_done:  done        = 1'b1;
            c_st_error: error       = 1'b1;
            default: begin
                flash_start = 1'b0;
            end
        endcase
    end

    assign hold_reset = ~done;

    //--------------------------------------------------------------------------
    // Byte datapath: toggle handshake, write strobe, count, checksum, ms timer
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flash_ack  <= 1'b0;
            r_bram_we    <= 1'b0;
            r_bram_a     <= '0;
            r_bram_d     <= '0;
            r_byte_count <= '0;
            r_checksum   <= '0;
            r_ms_count   <= '0;
        end else begin
            // Every state except START acknowledges what it sees: IDLE, DONE
            // and ERROR discard the byte, the loading states consume it.
            // START holds off so a toggle landing there is handled in
            // WAIT_BUSY rather than silently dropped.
            if (r_state != c_st_start) begin
                r_flash_ack <= flash_req;
            end

            r_bram_we <= w_accept;
            if (w_accept) begin
                r_bram_a <= flash_a;
                r_bram_d <= flash_q;
            end

            // Count and checksum follow the strobe, so they always describe
            // bytes that actually reached the BRAM.
            if (r_bram_we) begin
                r_byte_count <= r_byte_count + 1'b1;
                r_checksum   <= r_checksum + r_bram_d;
            end

            if (w_loading && ena_1khz && !w_timeout) begin
                r_ms_count <= r_ms_count + 1'b1;
            end

            if ((r_state == c_st_idle) && slot_valid) begin
                r_byte_count <= '0;
                r_checksum   <= '0;
                r_ms_count   <= '0;
            end
        end
    end

    assign flash_ack  = r_flash_ack;
    assign bram_we    = r_bram_we;
    assign bram_a     = r_bram_a;
    assign bram_d     = r_bram_d;
    assign byte_count = r_byte_count;
    assign checksum   = r_checksum;

endmodule
`default_nettype wire

// File: doc/cart_rom_loader.md
Name: cart_rom_loader

Overview:
- Sequences the power-up load of the cartridge ROM image from SPI NOR flash into the cartridge block RAM.
- Sits directly downstream of the SPI flash loader and upstream of the cart BRAM write port.
- Starts the flash loader and converts its toggle req/ack byte stream into single-cycle BRAM write strobes.
- Verifies byte count, enforces a timeout, and holds C64 reset and the SPI mux select until the image is good.

Parameters:
- a_bits, 14, width of flash/BRAM byte address.
- expected_bytes, 8192, number of bytes a complete load must deliver.
- timeout_ms, 2000, maximum ena_1khz ticks allowed from start pulse to completion.

Ports:
- clk  input  1  system clock (sysclk domain).
- reset  input  1  asynchronous, active-high reset.
- ena_1khz  input  1  one-cycle 1 kHz tick.
- slot_valid  input  1  flash slot number from USB micro is valid.
- retry  input  1  one-cycle request to restart after ERROR.
- flash_start  output  1  one-cycle start pulse to flash loader.
- flash_busy  input  1  flash loader busy.
- flash_req  input  1  toggle: new byte available.
- flash_ack  output  1  toggle acknowledge.
- flash_a  input  a_bits  byte address from flash loader.
- flash_q  input  8  byte data from flash loader.
- bram_we  output  1  one-cycle BRAM write strobe.
- bram_a  output  a_bits  BRAM write address.
- bram_d  output  8  BRAM write data.
- done  output  1  image loaded and verified (selects MMC64 onto SPI).
- error  output  1  load failed.
- hold_reset  output  1  keep C64 in reset.
- byte_count  output  a_bits+1  bytes written in current attempt.
- checksum  output  8  modulo-256 sum of bytes written.

Behaviour:
- Reset values:
  - flash_start, bram_we, done, error, flash_ack, bram_a, bram_d, byte_count, checksum, ms counter = 0.
  - hold_reset = 1; state = IDLE.
- States:
  - IDLE: flash_ack <= flash_req every cycle, discarding stale toggles. When slot_valid = 1, clear byte_count/checksum/ms counter, go START.
  - START: flash_start = 1 for exactly this cycle; go WAIT_BUSY.
  - WAIT_BUSY: on flash_busy = 1 go LOAD. A byte toggle arriving here is processed as in LOAD.
  - LOAD: byte handling and completion check as below.
  - DONE: terminal; only reset leaves it. Further toggles are acked but never written.
  - ERROR: on retry = 1 go IDLE. Toggles are acked, not written.
- Byte handling, when flash_req != flash_ack in WAIT_BUSY or LOAD:
  - Same cycle: register bram_a <= flash_a and bram_d <= flash_q, flash_ack <= flash_req.
  - Next cycle: bram_we = 1 for one cycle, byte_count += 1, checksum += bram_d (mod 256). Latency toggle-to-strobe is 1 cycle.
  - A new toggle may be accepted on the cycle bram_we is high, giving one byte per 2 cycles maximum.
- Completion check, in LOAD only, when flash_busy = 0, no toggle pending and bram_we = 0:
  - byte_count == expected_bytes -> DONE.
  - Otherwise -> ERROR.
  - Because of this rule, a final toggle arriving in the same cycle busy falls is always written and counted before the check.
- Overflow: a toggle arriving when byte_count == expected_bytes is acked, not written, and forces ERROR.
- Timeout: the ms counter increments on ena_1khz in WAIT_BUSY and LOAD. Reaching timeout_ms forces ERROR; the same-cycle completion check takes priority.
- done = 1 only in DONE. error = 1 only in ERROR. hold_reset = ~done.
- Asynchronous reset mid-load returns to IDLE at once. The partial BRAM contents are not cleared; the next load overwrites them.
- flash_start never pulses outside START. A retry outside ERROR is ignored.

Test Plan:
- Reset, then slot_valid=1 with a model that delivers 8192 bytes of value (addr & 0xFF) at addresses 0..8191 then drops busy → exactly 8192 bram_we pulses with bram_a = addr; done=1, hold_reset=0, byte_count=8192, checksum=0x00.
- Model drops busy after 8191 bytes → error=1, done=0, hold_reset=1. Then retry, a second full load → done=1 and exactly one additional flash_start pulse.
- Final byte toggled in the same cycle busy falls → that byte is written (8192nd bram_we) and the load ends in DONE, not ERROR.
- Model never asserts busy, with timeout_ms=3 and ena_1khz every 10 cycles → error=1 after the 3rd tick; no bram_we issued.
- Toggle flash_req in IDLE before slot_valid → no bram_we, flash_ack follows flash_req, byte_count=0.
- Assert reset at byte 4000 → all outputs at reset values; a new slot_valid restarts cleanly and ends with byte_count=8192, done=1.
